retire_trace_unit: RTL
======================

# retire_trace_unit

Retirement trace collector at the writeback end of the WISC-S18 CPU. Each cycle it captures at most one retiring instruction's architectural effect: a register write, a load, a store, a branch/NOP, or a halt. It classifies the event, numbers it, and buffers it in a small FIFO drained by the simulation logger over a valid/ready handshake. It also maintains cycle and instruction counters and a halt/drain state machine, so logging and halt reporting follow retirement order.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- CW, 32: width of cycle/instruction counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wb_valid  in  1  an instruction retires this cycle.
- wb_pc  in  16  PC of the retiring instruction.
- wb_reg_write  in  1  register file write.
- wb_reg  in  4  destination register.
- wb_data  in  16  register write data.
- wb_mem_read  in  1  instruction is a load.
- wb_mem_write  in  1  instruction is a store.
- wb_addr  in  16  memory address.
- wb_mem_data  in  16  store data.
- wb_halt  in  1  retiring instruction is HLT.
- ev_ready  in  1  consumer accepts the head event.
- ev_valid  out  1  head event is valid.
- ev_kind  out  3  event kind: 0 REG, 1 LOAD, 2 STORE, 3 OTHER, 4 HALT.
- ev_pc  out  16  PC of the event.
- ev_reg  out  4  destination register (REG/LOAD), else 0.
- ev_value  out  16  wb_data (REG/LOAD) or wb_mem_data (STORE), else 0.
- ev_addr  out  16  wb_addr (LOAD/STORE), else 0.
- ev_inum  out  CW  retirement number of the event, starting at 0.
- inst_count  out  CW  number of accepted retirements.
- cycle_count  out  CW  cycles since reset release.
- stall  out  1  FIFO full; the pipeline must hold writeback.
- halted  out  1  halt event drained; sticky.
- overflow_err  out  1  retirement dropped; sticky.

## Operation
- Classification, highest priority first:
  - wb_reg_write → LOAD if wb_mem_read, else REG.
  - else wb_halt → HALT.
  - else wb_mem_write → STORE.
  - else OTHER.
- Fields that do not apply to a kind are forced to 0.
- Accept condition: wb_valid && state==RUN && !full.
  - An accepted event is pushed with ev_inum = inst_count.
  - inst_count increments by 1 on each accept.
- Drop condition: wb_valid && state==RUN && full.
  - Nothing is pushed; inst_count is unchanged; overflow_err is set (sticky until rst).
- The FIFO is show-ahead: ev_* always reflect the head entry.
  - Pop on ev_valid && ev_ready.
  - Push and pop may occur in the same cycle when the FIFO is not full; occupancy is then unchanged.
  - A pop never frees space for a same-cycle push when full, so the event is dropped.
- stall = (occupancy == DEPTH), combinational from registered occupancy.
- State machine:
  - RUN → DRAIN when a HALT event is accepted.
  - DRAIN: all wb_valid is ignored (no count, no error). DRAIN → HALTED on the cycle the HALT entry pops.
  - HALTED: terminal until rst. halted=1; no pushes.
- cycle_count increments every cycle in RUN and DRAIN and freezes in HALTED. inst_count and cycle_count wrap modulo 2^CW.

## Timing
- Reset values:
  - state=RUN, FIFO empty, all counters 0.
  - ev_valid=0, ev_kind=0, ev_pc/reg/value/addr/inum=0.
  - stall=0, halted=0, overflow_err=0.
- Latency: an event accepted at edge N is visible with ev_valid=1 after edge N (cycle N+1). There is no combinational path from wb_* to ev_*.
- Handshake: ev_* are stable while ev_valid && !ev_ready. ev_ready is ignored when ev_valid=0.
- halted rises the cycle after the HALT pop edge.
- cycle_count reads 1 in the first cycle after the first edge with rst=0.
- rst asserted mid-operation clears everything immediately (asynchronously), including buffered events and a DRAIN in progress.
- Pointer wrap uses a DEPTH-modulo index plus an occupancy counter of log2(DEPTH)+1 bits.

## Test plan
- REG write with ev_ready=1:
  - Stimulus: wb_valid, reg_write, reg=3, data=0x1234, pc=0x0002.
  - Required: next cycle ev_valid=1, kind=0, reg=3, value=0x1234, inum=0; inst_count=1.
- Load plus store back-to-back:
  - Stimulus: LOAD (reg 5, addr 0x0010, data 0xBEEF), then STORE (addr 0x0020, mem_data 0x00AA).
  - Required: kind 1 (addr=0x0010, value=0xBEEF), then kind 2 (value=0x00AA); inum 0 then 1.
- Backpressure:
  - Stimulus: ev_ready=0; retire 4 OTHER events.
  - Required: stall=1 after the 4th. A 5th wb_valid sets overflow_err and leaves inst_count=4. Then ev_ready=1 drains inum 0,1,2,3 in order.
- Halt drain:
  - Stimulus: 2 REG events, then HALT, then wb_valid REG; ev_ready=0 for 3 cycles, then 1.
  - Required: the post-halt REG is ignored; HALT has inum=2. halted=1 the cycle after the HALT pop; cycle_count frozen from then.
- Simultaneous push/pop at occupancy 1:
  - Required: occupancy stays 1, order preserved, no overflow_err.
- Async reset mid-DRAIN:
  - Stimulus: assert rst between edges.
  - Required: ev_valid, stall and halted drop to 0 immediately; counters read 0.

Source files
------------

// File: rtl/retire_trace_unit.sv
// retire_trace_unit
//   Writeback-side retirement trace collector. Classifies each retiring
//   instruction (REG/LOAD/STORE/OTHER/HALT), numbers it and queues it in a
//   show-ahead FIFO that the logger drains over a valid/ready handshake.
//   Also keeps cycle/instruction counters and a RUN/DRAIN/HALTED machine
//   so that halt reporting follows retirement order.
// Ports:
//   clk, rst                 clock, async active-high reset
//   wb_*                     retiring instruction's architectural effect
//   ev_ready / ev_valid      logger handshake on the FIFO head
//   ev_kind..ev_inum         head event fields (0 when no event is held)
//   inst_count, cycle_count  accepted retirements / cycles since reset
//   stall                    FIFO full, writeback must hold
//   halted, overflow_err     sticky status flags
module retire_trace_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [15:0]   wb_pc,
  input  logic          wb_reg_write,
  input  logic [3:0]    wb_reg,
  input  logic [15:0]   wb_data,
  input  logic          wb_mem_read,
  input  logic          wb_mem_write,
  input  logic [15:0]   wb_addr,
  input  logic [15:0]   wb_mem_data,
  input  logic          wb_halt,
  input  logic          ev_ready,
  output logic          ev_valid,
  output logic [2:0]    ev_kind,
  output logic [15:0]   ev_pc,
  output logic [3:0]    ev_reg,
  output logic [15:0]   ev_value,
  output logic [15:0]   ev_addr,
  output logic [CW-1:0] ev_inum,
  output logic [CW-1:0] inst_count,
  output logic [CW-1:0] cycle_count,
  output logic          stall,
  output logic          halted,
  output logic          overflow_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef enum logic [2:0] {
    K_REG   = 3'd0,
    K_LOAD  = 3'd1,
    K_STORE = 3'd2,
    K_OTHER = 3'd3,
    K_HALT  = 3'd4
  } kind_t;

  state_t        state;
  logic [AW:0]   count_q;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [2:0]    kind_mem  [DEPTH];
  logic [15:0]   pc_mem    [DEPTH];
  logic [3:0]    reg_mem   [DEPTH];
  logic [15:0]   value_mem [DEPTH];
  logic [15:0]   addr_mem  [DEPTH];
  logic [CW-1:0] inum_mem  [DEPTH];

  kind_t       in_kind;
  logic [3:0]  in_reg;
  logic [15:0] in_value;
  logic [15:0] in_addr;

  logic full;
  logic accept;
  logic drop;
  logic pop;

  // Classification; fields that do not apply to the kind are zeroed.
  always_comb begin
    in_kind  = K_OTHER;
    in_reg   = '0;
    in_value = '0;
    in_addr  = '0;
    if (wb_reg_write) begin
      in_reg   = wb_reg;
      in_value = wb_data;
      if (wb_mem_read) begin
        in_kind = K_LOAD;
        in_addr = wb_addr;
      end else begin
        in_kind = K_REG;
      end
    end else if (wb_halt) begin
      in_kind = K_HALT;
    end else if (wb_mem_write) begin
      in_kind  = K_STORE;
      in_value = wb_mem_data;
      in_addr  = wb_addr;
    end
  end

  assign full     = (count_q == FULL_COUNT);
  assign ev_valid = (count_q != '0);
  assign accept   = wb_valid && (state == RUN) && !full;
  // A same-cycle pop does not make room when full: the event is lost.
  assign drop     = wb_valid && (state == RUN) && full;
  assign pop      = ev_valid && ev_ready;

  assign stall  = full;
  assign halted = (state == HALTED);

  // Head fields are masked when empty so stale entries never show.
  assign ev_kind  = ev_valid ? kind_mem[rd_ptr]  : '0;
  assign ev_pc    = ev_valid ? pc_mem[rd_ptr]    : '0;
  assign ev_reg   = ev_valid ? reg_mem[rd_ptr]   : '0;
  assign ev_value = ev_valid ? value_mem[rd_ptr] : '0;
  assign ev_addr  = ev_valid ? addr_mem[rd_ptr]  : '0;
  assign ev_inum  = ev_valid ? inum_mem[rd_ptr]  : '0;

  // Storage needs no reset: validity is carried by count_q alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      kind_mem[wr_ptr]  <= in_kind;
      pc_mem[wr_ptr]    <= wb_pc;
      reg_mem[wr_ptr]   <= in_reg;
      value_mem[wr_ptr] <= in_value;
      addr_mem[wr_ptr]  <= in_addr;
      inum_mem[wr_ptr]  <= inst_count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      count_q      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      inst_count   <= '0;
      cycle_count  <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr     <= wr_ptr + 1'b1;
        inst_count <= inst_count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_err <= 1'b1;
      end
      if (state != HALTED) begin
        cycle_count <= cycle_count + 1'b1;
      end
      case (state)
        RUN:     if (accept && in_kind == K_HALT) state <= DRAIN;
        DRAIN:   if (pop && kind_mem[rd_ptr] == K_HALT) state <= HALTED;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

endmodule
